fir_mean_ctrl: RTL

Configuration sequencer and output qualifier for the per-channel moving-average filter (`fir_mean_filt`) in the acquisition datapath. It accepts host writes of enable and tap count, validates them, and applies them with a one-cycle filter soft reset. It masks filter outputs whose averaging window is incomplete or stale, so downstream decimation and packing logic only sees fully-formed averages. One instance sits beside each filter instance, between the register bank and the filter.

---
 rtl/fir_mean_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fir_mean_ctrl.sv
// rtl/fir_mean_ctrl.sv - configuration sequencer and output qualifier for fir_mean_filt
//
// Accepts host writes of filter enable and tap code, and rejects illegal tap codes
// by setting a sticky error. It applies each accepted write with a one-cycle filter
// soft reset. It tags every input sample and masks filter outputs whose averaging
// window is incomplete or was in flight across a reconfiguration.
//
// Optional feature macro: FIR_MEAN_CTRL_STAT_EN (builds the dropped-output counter).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_wr                   configuration write strobe
//   cfg_fir_en, cfg_fir_dec  requested enable and tap code (window = code + 1)
//   cfg_err_clr              clears cfg_err (and the drop counter when built)
//   cfg_busy                 high while a configuration is being applied/filled
//   cfg_err                  sticky illegal-tap-code flag
//   ivld                     input sample strobe shared with the filter
//   flt_soft_rst             one-cycle soft reset to the filter
//   flt_fir_en, flt_fir_dec  configuration driven to the filter
//   flt_ovld, flt_odata      raw filter output
//   ovld, odata              qualified, registered output
//   stat_drop_cnt            saturating count of masked filter outputs
module fir_mean_ctrl #(
  parameter int DATA_WD  = 16,
  parameter int DEC_WD   = 6,
  parameter int MAX_MEAN = 40,
  parameter int FLT_LAT  = 4   // must be >= 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic               cfg_fir_en,
  input  logic [DEC_WD-1:0]  cfg_fir_dec,
  input  logic               cfg_err_clr,
  output logic               cfg_busy,
  output logic               cfg_err,
  input  logic               ivld,
  output logic               flt_soft_rst,
  output logic               flt_fir_en,
  output logic [DEC_WD-1:0]  flt_fir_dec,
  input  logic               flt_ovld,
  input  logic [DATA_WD-1:0] flt_odata,
  output logic               ovld,
  output logic [DATA_WD-1:0] odata,
  output logic [15:0]        stat_drop_cnt
);

  typedef enum logic [1:0] {S_RUN, S_APPLY, S_FILL} state_t;

  localparam logic [DEC_WD:0] MAX_CODE = (DEC_WD+1)'(MAX_MEAN);

  state_t               state_q, state_d;
  logic                 fen_q, fen_d;
  logic [DEC_WD-1:0]    fdec_q, fdec_d;
  logic [DEC_WD-1:0]    fill_q, fill_d;
  logic                 err_q, err_d;
  logic [FLT_LAT-1:0]   tag_q, tag_d;
  logic                 ovld_q, ovld_d;
  logic [DATA_WD-1:0]   odata_q, odata_d;
  logic                 new_tag;
  logic                 clr_tags;
  logic                 wr_legal, wr_bad;

  assign wr_legal = cfg_wr & ({1'b0, cfg_fir_dec} < MAX_CODE);
  assign wr_bad   = cfg_wr & ~wr_legal;

  always_comb begin
    state_d  = state_q;
    fen_d    = fen_q;
    fdec_d   = fdec_q;
    fill_d   = fill_q;
    new_tag  = 1'b1;
    clr_tags = 1'b0;

    case (state_q)
      S_APPLY: begin
        // Everything in flight belongs to the old configuration or to the
        // filter's reset cycle, including this cycle's sample.
        clr_tags = 1'b1;
        fill_d   = '0;
        state_d  = fen_q ? S_FILL : S_RUN;
      end
      S_FILL: begin
        new_tag = 1'b0;
        if (ivld) begin
          if (fill_q >= fdec_q) begin
            new_tag = 1'b1;
            state_d = S_RUN;
          end
          fill_d = fill_q + 1'b1;
        end
      end
      default: new_tag = 1'b1;
    endcase

    // The filter-facing registers double as the shadow: loading them on the
    // write edge makes the new values visible in the APPLY cycle itself.
    if (wr_legal) begin
      fen_d   = cfg_fir_en;
      fdec_d  = cfg_fir_dec;
      state_d = S_APPLY;
    end

    tag_d = clr_tags ? '0 : {tag_q[FLT_LAT-2:0], new_tag};

    // Set wins over clear.
    err_d = wr_bad ? 1'b1 : (cfg_err_clr ? 1'b0 : err_q);

    ovld_d  = flt_ovld & tag_q[FLT_LAT-1];
    odata_d = flt_ovld ? flt_odata : odata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      fen_q   <= 1'b0;
      fdec_q  <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
      tag_q   <= '1;
      ovld_q  <= 1'b0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      fen_q   <= fen_d;
      fdec_q  <= fdec_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
      ovld_q  <= ovld_d;
      odata_q <= odata_d;
    end
  end

  assign cfg_busy     = (state_q != S_RUN);
  assign cfg_err      = err_q;
  assign flt_soft_rst = (state_q == S_APPLY);
  assign flt_fir_en   = fen_q;
  assign flt_fir_dec  = fdec_q;
  assign ovld         = ovld_q;
  assign odata        = odata_q;

`ifdef FIR_MEAN_CTRL_STAT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (cfg_err_clr)
      drop_d = '0;
    else if (flt_ovld && !tag_q[FLT_LAT-1] && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign stat_drop_cnt = drop_q;
`else
  assign stat_drop_cnt = '0;
`endif

endmodule
